// File: rtl/imm_gen_stage.sv
// Registered RV32/RV64 immediate generator with format classification, illegal-encoding
// detection and a one-entry skid buffer behind a valid/ready handshake.
module imm_gen_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [1:0]      o_dbg_state
);
    localparam bit IS64 = (XLEN == 64);

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_MISC    = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4, FMT_J = 3'd5, FMT_SH = 3'd6;

    typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_TWO = 2'd2} state_t;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } beat_t;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic        w_f3_shift;
    logic        w_sh_bad;
    logic [31:0] w_imm32;
    logic [2:0]  w_fmt;
    logic        w_ill;
    logic [XLEN-1:0] w_imm;
    beat_t       w_beat;

    assign w_opc      = in_inst[6:0];
    assign w_f3       = in_inst[14:12];
    assign w_f3_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
    // Reserved shift-encoding bits shared by every shift form; inst[30] selects SRA only.
    assign w_sh_bad   = in_inst[31] | (|in_inst[29:26]) | (in_inst[30] & (w_f3 == 3'b001));

    always_comb begin
        w_fmt   = FMT_R;
        w_imm32 = '0;
        w_ill   = 1'b0;
        if (in_inst[1:0] != 2'b11) begin
            w_ill = 1'b1;
        end else begin
            case (w_opc)
                OPC_LOAD, OPC_JALR, OPC_MISC, OPC_SYSTEM: begin
                    w_fmt   = FMT_I;
                    w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                end
                OPC_OPIMM: begin
                    if (w_f3_shift) begin
                        w_fmt = FMT_SH;
                        if (IS64) begin
                            w_imm32 = {26'b0, in_inst[25:20]};
                            w_ill   = w_sh_bad;
                        end else begin
                            w_imm32 = {27'b0, in_inst[24:20]};
                            w_ill   = w_sh_bad | in_inst[25];
                        end
                    end else begin
                        w_fmt   = FMT_I;
                        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                    end
                end
                OPC_OPIMM32: begin
                    if (!IS64) begin
                        w_ill = 1'b1;
                    end else if (w_f3 == 3'b000) begin
                        w_fmt   = FMT_I;
                        w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
                    end else if (w_f3_shift) begin
                        w_fmt   = FMT_SH;
                        w_imm32 = {27'b0, in_inst[24:20]};
                        w_ill   = w_sh_bad | in_inst[25];
                    end else begin
                        w_ill = 1'b1;
                    end
                end
                OPC_STORE: begin
                    w_fmt   = FMT_S;
                    w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                end
                OPC_BRANCH: begin
                    w_fmt   = FMT_B;
                    w_imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    w_fmt   = FMT_U;
                    w_imm32 = {in_inst[31:12], 12'b0};
                end
                OPC_JAL: begin
                    w_fmt   = FMT_J;
                    w_imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
                end
                OPC_OP:   w_fmt = FMT_R;
                OPC_OP32: w_ill = !IS64;
                default:  w_ill = 1'b1;
            endcase
        end
    end

    // Every immediate fits in 32 bits once sign-extended, so RV64 only replicates bit 31.
    generate
        if (IS64) begin : g_ext64
            assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
        end else begin : g_ext32
            assign w_imm = w_imm32;
        end
    endgenerate

    assign w_beat = '{inst: in_inst, pc: in_pc, imm: w_imm, fmt: w_fmt, ill: w_ill};

    // Handshake: a beat moves on a side only in a cycle where that side's valid and
    // ready are both high; valid never depends on ready, and in_ready is a flop.
    state_t r_state, w_next;
    logic   r_in_ready;
    beat_t  r_out, r_skid;
    logic   w_accept, w_take;
    logic   w_ld_out_in, w_ld_out_skid, w_ld_skid;

    assign w_accept = in_valid & r_in_ready;
    assign w_take   = out_valid & out_ready;

    always_comb begin
        w_next        = r_state;
        w_ld_out_in   = 1'b0;
        w_ld_out_skid = 1'b0;
        w_ld_skid     = 1'b0;
        case (r_state)
            S_EMPTY: if (w_accept) begin
                w_next      = S_ONE;
                w_ld_out_in = 1'b1;
            end
            S_ONE: begin
                if (w_accept && w_take) begin
                    w_ld_out_in = 1'b1;
                end else if (w_accept) begin
                    w_next    = S_TWO;
                    w_ld_skid = 1'b1;
                end else if (w_take) begin
                    w_next = S_EMPTY;
                end
            end
            S_TWO: if (w_take) begin
                w_next        = S_ONE;
                w_ld_out_skid = 1'b1;
            end
            default: w_next = S_EMPTY;
        endcase
        if (flush) begin
            w_next        = S_EMPTY;
            w_ld_out_in   = 1'b0;
            w_ld_out_skid = 1'b0;
            w_ld_skid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b1;
            r_out      <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next != S_TWO);
            if (w_ld_out_in) begin
                r_out <= w_beat;
            end else if (w_ld_out_skid) begin
                r_out <= r_skid;
            end
            if (w_ld_skid) begin
                r_skid <= w_beat;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state != S_EMPTY);
    assign out_inst    = r_out.inst;
    assign out_pc      = r_out.pc;
    assign out_imm     = r_out.imm;
    assign out_fmt     = r_out.fmt;
    assign out_illegal = r_out.ill;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: an XLEN=64 and an XLEN=32 instance share one stimulus stream
// and are checked every cycle against a queue-based model of the stage.
module tb_imm_gen_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [31:0] out_inst64;
    logic [63:0] out_pc64, out_imm64;
    logic [2:0]  out_fmt64;
    logic [1:0]  dbg64;

    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_inst32, out_pc32, out_imm32;
    logic [2:0]  out_fmt32;
    logic [1:0]  dbg32;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid64), .out_ready(out_ready),
        .out_inst(out_inst64), .out_pc(out_pc64), .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_illegal(out_illegal64), .o_dbg_state(dbg64)
    );

    imm_gen_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
        .out_inst(out_inst32), .out_pc(out_pc32), .out_imm(out_imm32), .out_fmt(out_fmt32),
        .out_illegal(out_illegal32), .o_dbg_state(dbg32)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference decode ----------------
    function automatic void model_dec(input logic [31:0] w, input bit x64,
                                      output logic [2:0] f, output logic [63:0] imm,
                                      output logic il);
        logic [6:0] op;
        logic [2:0] f3;
        longint     v;
        op = w[6:0];
        f3 = w[14:12];
        f  = 3'd0;
        v  = 0;
        il = 1'b0;
        if (w[1:0] != 2'b11) begin
            il = 1'b1;
        end else if (op == 7'h03 || op == 7'h67 || op == 7'h0F || op == 7'h73 ||
                     (op == 7'h13 && f3 != 3'd1 && f3 != 3'd5) ||
                     (op == 7'h1B && x64 && f3 == 3'd0)) begin
            f = 3'd1;
            v = longint'($signed(w[31:20]));
        end else if ((op == 7'h13 || (op == 7'h1B && x64)) && (f3 == 3'd1 || f3 == 3'd5)) begin
            f = 3'd6;
            if (x64 && op == 7'h13) begin
                v = longint'({58'b0, w[25:20]});
            end else begin
                v = longint'({59'b0, w[24:20]});
                if (w[25]) il = 1'b1;
            end
            if (w[31] || w[29:26] != 4'b0 || (w[30] && f3 == 3'd1)) il = 1'b1;
        end else if (op == 7'h23) begin
            f = 3'd2;
            v = longint'($signed({w[31:25], w[11:7]}));
        end else if (op == 7'h63) begin
            f = 3'd3;
            v = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
        end else if (op == 7'h37 || op == 7'h17) begin
            f = 3'd4;
            v = longint'($signed({w[31:12], 12'b0}));
        end else if (op == 7'h6F) begin
            f = 3'd5;
            v = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
        end else if (op == 7'h33 || (op == 7'h3B && x64)) begin
            f = 3'd0;
        end else begin
            il = 1'b1;
        end
        imm = x64 ? 64'(v) : {32'b0, v[31:0]};
    endfunction

    // ---------------- scoreboard: model queue of {pc, inst} ----------------
    logic [95:0] exp_q[$];
    logic [31:0] got_q[$];
    bit          m_live = 1'b0;
    bit          m_zero = 1'b0;

    always @(posedge clk) begin
        bit take, acc;
        if (rst) begin
            exp_q.delete();
            m_live = 1'b1;
            m_zero = 1'b1;
        end else if (m_live) begin
            if (flush) begin
                exp_q.delete();
            end else begin
                take = (exp_q.size() > 0) && out_ready;
                acc  = in_valid && (exp_q.size() < 2);
                if (take) void'(exp_q.pop_front());
                if (acc) begin
                    exp_q.push_back({in_pc, in_inst});
                    m_zero = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [2:0]  f;
        logic [63:0] imm;
        logic        il;
        logic        ev, er;
        if (m_live) begin
            ev = (exp_q.size() > 0);
            er = (exp_q.size() < 2);
            chk("valid64", 64'(out_valid64), 64'(ev));
            chk("ready64", 64'(in_ready64), 64'(er));
            chk("valid32", 64'(out_valid32), 64'(ev));
            chk("ready32", 64'(in_ready32), 64'(er));
            if (ev) begin
                model_dec(exp_q[0][31:0], 1'b1, f, imm, il);
                chk("inst64", 64'(out_inst64), 64'(exp_q[0][31:0]));
                chk("pc64", out_pc64, exp_q[0][95:32]);
                chk("imm64", out_imm64, imm);
                chk("fmt64", 64'(out_fmt64), 64'(f));
                chk("ill64", 64'(out_illegal64), 64'(il));
                model_dec(exp_q[0][31:0], 1'b0, f, imm, il);
                chk("inst32", 64'(out_inst32), 64'(exp_q[0][31:0]));
                chk("pc32", 64'(out_pc32), 64'(exp_q[0][63:32]));
                chk("imm32", 64'(out_imm32), imm);
                chk("fmt32", 64'(out_fmt32), 64'(f));
                chk("ill32", 64'(out_illegal32), 64'(il));
            end else if (m_zero) begin
                chk("rstdata64", {out_imm64 | out_pc64}, 64'd0);
                chk("rstmisc64", {29'b0, out_inst64, out_fmt64}, 64'd0);
                chk("rstill", 64'({out_illegal64, out_illegal32}), 64'd0);
            end
            if (out_valid64 && out_ready) got_q.push_back(out_inst64);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] inst;
        logic [2:0]  f64;
        logic [63:0] i64;
        logic        il64;
        logic [2:0]  f32;
        logic [31:0] i32;
        logic        il32;
    } vec_t;
    localparam int NV = 16;
    vec_t vt[NV];

    initial begin
        vt[0]  = '{32'hFFF00093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd1, 32'hFFFF_FFFF, 1'b0};
        vt[1]  = '{32'h43F0D093, 3'd6, 64'h3F,                  1'b0, 3'd6, 32'h1F,        1'b1};
        vt[2]  = '{32'h800000B7, 3'd4, 64'hFFFF_FFFF_8000_0000, 1'b0, 3'd4, 32'h8000_0000, 1'b0};
        vt[3]  = '{32'hFE000EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 3'd3, 32'hFFFF_FFFC, 1'b0};
        vt[4]  = '{32'h00000000, 3'd0, 64'h0,                   1'b1, 3'd0, 32'h0,         1'b1};
        vt[5]  = '{32'h00513823, 3'd2, 64'h10,                  1'b0, 3'd2, 32'h10,        1'b0};
        vt[6]  = '{32'h0080006F, 3'd5, 64'h8,                   1'b0, 3'd5, 32'h8,         1'b0};
        vt[7]  = '{32'h0010809B, 3'd1, 64'h1,                   1'b0, 3'd0, 32'h0,         1'b1};
        vt[8]  = '{32'h01F0909B, 3'd6, 64'h1F,                  1'b0, 3'd0, 32'h0,         1'b1};
        vt[9]  = '{32'h02009093, 3'd6, 64'h20,                  1'b0, 3'd6, 32'h0,         1'b1};
        vt[10] = '{32'h003100B3, 3'd0, 64'h0,                   1'b0, 3'd0, 32'h0,         1'b0};
        vt[11] = '{32'h003100BB, 3'd0, 64'h0,                   1'b0, 3'd0, 32'h0,         1'b1};
        vt[12] = '{32'h0000007F, 3'd0, 64'h0,                   1'b1, 3'd0, 32'h0,         1'b1};
        vt[13] = '{32'h0000A09B, 3'd0, 64'h0,                   1'b1, 3'd0, 32'h0,         1'b1};
        vt[14] = '{32'h40009093, 3'd6, 64'h0,                   1'b1, 3'd6, 32'h0,         1'b1};
        vt[15] = '{32'hFFF12083, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd1, 32'hFFFF_FFFF, 1'b0};
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_until_taken(input logic [31:0] inst, input logic [63:0] pc);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        for (int k = 0; k < 10 && !done; k++) begin
            done = in_ready64;
            tick();
        end
        in_valid = 1'b0;
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [2:0]  f;
        logic [63:0] imm;
        logic        il;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_inst = '0; in_pc = '0;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid64), 64'd0);
        chk("rst_ready", 64'(in_ready64), 64'd1);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            model_dec(vt[i].inst, 1'b1, f, imm, il);
            chk($sformatf("pin64_%0d", i), {imm[59:0], f, il}, {vt[i].i64[59:0], vt[i].f64, vt[i].il64});
            model_dec(vt[i].inst, 1'b0, f, imm, il);
            chk($sformatf("pin32_%0d", i), {imm[31:0], 28'b0, f, il}, {vt[i].i32, 28'b0, vt[i].f32, vt[i].il32});
        end

        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            in_inst  = vt[i].inst;
            in_pc    = 64'h8000_0000_0000_1000 + 64'(i * 4);
            tick();
            chk($sformatf("lat_valid_%0d", i), 64'(out_valid64), 64'd1);
            chk($sformatf("lat_imm64_%0d", i), out_imm64, vt[i].i64);
            chk($sformatf("lat_ill32_%0d", i), 64'(out_illegal32), 64'(vt[i].il32));
        end
        in_valid = 1'b0;
        tick();
        tick();

        got_q.delete();
        out_ready = 1'b0;
        send(32'h00100093, 64'hA0);
        send(32'h00200113, 64'hB0);
        chk("two_ready", 64'(in_ready64), 64'd0);
        chk("two_head", 64'(out_inst64), 64'h00100093);
        in_valid = 1'b1;
        in_inst  = 32'h00300193;
        in_pc    = 64'hC0;
        tick();
        chk("two_hold", 64'(out_inst64), 64'h00100093);
        out_ready = 1'b1;
        send_until_taken(32'h00300193, 64'hC0);
        repeat (4) tick();
        chk("abc_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() == 3) begin
            chk("abc_0", 64'(got_q[0]), 64'h00100093);
            chk("abc_1", 64'(got_q[1]), 64'h00200113);
            chk("abc_2", 64'(got_q[2]), 64'h00300193);
        end

        got_q.delete();
        out_ready = 1'b0;
        send(32'h00400213, 64'hD0);
        send(32'h00500293, 64'hE0);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 32'h00600313;
        in_pc    = 64'hF0;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid64), 64'd0);
        chk("flush_ready", 64'(in_ready64), 64'd1);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("flush_none", 64'(got_q.size()), 64'd0);

        out_ready = 1'b0;
        send(32'h00700393, 64'h100);
        send(32'h00800413, 64'h108);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_valid", 64'(out_valid64), 64'd0);
        chk("rst2_ready", 64'(in_ready64), 64'd1);
        chk("rst2_inst", 64'(out_inst64), 64'd0);
        chk("rst2_pc", out_pc64, 64'd0);
        chk("rst2_imm", out_imm64, 64'd0);
        chk("rst2_fmt", 64'(out_fmt64), 64'd0);

        out_ready = 1'b1;
        send(32'h00000000, 64'h200);
        chk("zero_ill", 64'(out_illegal64), 64'd1);
        chk("zero_fmt", 64'(out_fmt64), 64'd0);
        chk("zero_imm", out_imm64, 64'd0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imm_gen_stage.md
Name:
imm_gen_stage

Overview:
- Registered decode-side immediate generator for the RV64I pipeline. Successor to the RV32 combinational immediate extender.
- Parametrised in XLEN (32/64). Adds RV64 6-bit shift amounts, OP-IMM-32 support, format classification and illegal-encoding detection.
- Sits between IF/ID and the ID/EX operand mux behind a valid/ready handshake.
- Includes a one-entry skid buffer, so upstream stalls are registered and never combinational.

Parameters:
- XLEN, 64, datapath width; legal values are 32 and 64. Controls immediate width and shift rules.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all held and incoming instructions (branch/trap redirect).
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; a registered output.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- out_valid  out  1  output bundle valid.
- out_ready  in  1  downstream accepts.
- out_inst  out  32  instruction passthrough.
- out_pc  out  XLEN  PC passthrough.
- out_imm  out  XLEN  extended immediate.
- out_fmt  out  3  format: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT.
- out_illegal  out  1  encoding illegal for this XLEN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, in_ready=1.
  - out_imm, out_pc, out_inst = 0; out_fmt=0; out_illegal=0.
  - Skid buffer empty.
  - Reset mid-transfer drops everything.
- Handshake:
  - An input beat is accepted when in_valid & in_ready.
  - An output beat is taken when out_valid & out_ready.
  - Latency is 1 cycle when unstalled. Full throughput: one beat per cycle.
  - Output fields hold stable while out_valid & !out_ready.
- Skid buffer:
  - If the output register is occupied and not taken while a beat is accepted, that beat goes to the skid entry and in_ready is 0 next cycle.
  - When the output is taken and the skid entry is full, the skid entry moves to the output and in_ready returns to 1 next cycle.
  - Order is always preserved.
- States:
  - EMPTY (out_valid=0), ONE (output register full), TWO (output and skid full).
  - EMPTY→ONE on accept.
  - ONE→EMPTY on take without accept.
  - ONE→TWO on accept without take.
  - TWO→ONE on take. No accept is possible in TWO.
- Flush:
  - Flush has priority over all events.
  - Next cycle: EMPTY, out_valid=0, in_ready=1.
  - A beat presented in the flush cycle is dropped even if in_valid & in_ready.
- Decode is computed on the input side and registered alongside the instruction (opc=inst[6:0], f3=inst[14:12]).
- Immediate construction, all sign-extended from inst[31] to XLEN:
  - I format (fmt 1): LOAD 0000011, JALR 1100111, MISC-MEM 0001111, SYSTEM 1110011, and OP-IMM 0010011 with f3∉{001,101}. imm = sext(inst[31:20]).
  - OP-IMM-32 0011011 with f3=000 is also fmt 1 when XLEN=64.
  - S format (fmt 2): STORE 0100011. imm = sext({inst[31:25],inst[11:7]}).
  - B format (fmt 3): BRANCH 1100011. imm = sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
  - U format (fmt 4): LUI 0110111, AUIPC 0010111. imm = sext({inst[31:12],12'b0}); on XLEN=64 bits 63:32 copy inst[31].
  - J format (fmt 5): JAL 1101111. imm = sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
- Shift format (fmt 6): OP-IMM with f3∈{001,101}, and OP-IMM-32 with f3∈{001,101}. imm is zero-extended shamt.
  - XLEN=64, OP-IMM: shamt=inst[25:20].
  - OP-IMM-32, or XLEN=32: shamt=inst[24:20]; illegal if inst[25]=1.
  - Illegal also if inst[31] or inst[29:26] is nonzero, or if inst[30]=1 with f3=001.
- R format (fmt 0, imm 0): OP 0110011. OP-32 0111011 (XLEN=64 only).
- Illegal (fmt 0, imm 0, out_illegal=1):
  - inst[1:0]≠11.
  - Unknown opcode.
  - OP-32 or OP-IMM-32 when XLEN=32.
  - OP-IMM-32 with f3∉{000,001,101}.
- Illegal instructions still flow through the handshake normally.

Test Plan:
- XLEN=64: ADDI 0xFFF00093 → after 1 cycle, out_valid=1, fmt=1, imm=0xFFFF_FFFF_FFFF_FFFF, illegal=0.
- XLEN=64: SRAI x1,x1,63 (0x43F0D093) → fmt=6, imm=0x3F, illegal=0. Same word with XLEN=32 → illegal=1.
- XLEN=64: LUI 0x800000B7 → imm=0xFFFF_FFFF_8000_0000. BEQ 0xFE000EE3 → fmt=3, imm=0xFFFF_FFFF_FFFF_FFFC.
- Back-to-back beats A, B, C with out_ready held 0 for 2 cycles:
  - A held on the output, B in the skid, in_ready=0 while C waits.
  - Then raise out_ready → outputs A, B, C in order, no loss or duplication.
- State TWO plus flush asserted together with in_valid=1 → next cycle out_valid=0, in_ready=1; no beat from before or during the flush ever appears.
- rst asserted mid-stall → all outputs at reset values next cycle. 0x00000000 (inst[1:0]=00) → illegal=1, fmt=0, imm=0.
